key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/key_debounce.sv | 121 ++++++++++++
 tb/tb_key_debounce.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: FSM states, hold-counter
// width and the default timing parameters.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } key_state_t;

  localparam int unsigned HOLD_W         = 16;
  localparam int unsigned STABLE_CNT_DEF = 10;
  localparam int unsigned LONG_CNT_DEF   = 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RST_VAL so the output comes out of reset at a known idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Tick-sampled push-button debouncer with registered level, press/release
// pulses and a one-shot long-press pulse.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1khz,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

  key_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
  logic              w_key_sync, w_key_s, w_stable, w_hold_max;
  logic              w_press_nxt, w_release_nxt, w_long_nxt, w_level_nxt;

  // key_n idles high, so the synchronizer resets to the released level.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (key_n),
    .o_q   (w_key_sync)
  );

  assign w_key_s    = ~w_key_sync;
  // cnt is zero in IDLE and PRESSED, so one incrementer serves the first sample too.
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_stable   = (w_cnt_inc == CNT_W'(STABLE_CNT));
  assign w_hold_inc = r_hold + HOLD_W'(1);
  assign w_hold_max = &r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (tick_1khz) begin
      unique case (r_state)
        ST_IDLE:         if (w_key_s)  w_state_nxt = w_stable ? ST_PRESSED : ST_PRESS_WAIT;
        ST_PRESS_WAIT:   if (!w_key_s) w_state_nxt = ST_IDLE;
                         else if (w_stable) w_state_nxt = ST_PRESSED;
        ST_PRESSED:      if (!w_key_s) w_state_nxt = w_stable ? ST_IDLE : ST_RELEASE_WAIT;
        ST_RELEASE_WAIT: if (w_key_s)  w_state_nxt = ST_PRESSED;
                         else if (w_stable) w_state_nxt = ST_IDLE;
        default:         w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_level_nxt   = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
    if (tick_1khz) begin
      unique case (r_state)
        ST_IDLE, ST_PRESS_WAIT: begin
          if (!w_key_s) begin
            w_cnt_nxt = '0;
          end else if (w_stable) begin
            w_cnt_nxt   = '0;
            w_hold_nxt  = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_PRESSED, ST_RELEASE_WAIT: begin
          if (w_key_s) begin
            w_cnt_nxt = '0;
            // Hold only advances on uninterrupted PRESSED samples, and is
            // monotonic within a press, so the equality fires at most once.
            if (r_state == ST_PRESSED && !w_hold_max) begin
              w_hold_nxt = w_hold_inc;
              w_long_nxt = (w_hold_inc == HOLD_W'(LONG_CNT));
            end
          end else if (w_stable) begin
            w_cnt_nxt     = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_hold        <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_hold        <= w_hold_nxt;
      key_level     <= w_level_nxt;
      press_pulse   <= w_press_nxt;
      release_pulse <= w_release_nxt;
      long_pulse    <= w_long_nxt;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random bounce
// patterns, compared each cycle against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned STABLE = 10;
  localparam int unsigned LONG   = 500;
  localparam int unsigned P      = 16;

  logic clk = 1'b0, reset = 1'b1, tick_1khz = 1'b0, key_n = 1'b1;
  logic key_level, press_pulse, release_pulse, long_pulse;

  int n_vec = 0, n_err = 0;
  int np = 0, nr = 0, nl = 0;
  int sp, sr, sl, lat;

  key_debounce #(.STABLE_CNT(STABLE), .LONG_CNT(LONG)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1khz     (tick_1khz),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int tcnt = 0;
  always @(negedge clk) begin
    tcnt      = (tcnt == P - 1) ? 0 : tcnt + 1;
    tick_1khz = (tcnt == 0);
  end

  // Reference: debounced level flips after STABLE consecutive disagreeing samples.
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0;
  logic e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;
  int   m_run = 0, m_hold = 0;
  logic smp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_run = 0; m_hold = 0;
      e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    end else begin
      e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
      if (tick_1khz) begin
        smp = ~m_s2;
        if (smp != m_lvl) begin
          m_run++;
          if (m_run == STABLE) begin
            m_lvl = smp;
            m_run = 0;
            if (smp) begin e_press = 1'b1; m_hold = 0; end
            else e_rel = 1'b1;
          end
        end else if (m_lvl && m_run == 0) begin
          if (m_hold < 65535) begin
            m_hold++;
            if (m_hold == LONG) e_long = 1'b1;
          end
        end else begin
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  end

  always @(negedge clk) begin
    check_eq("outputs", {28'd0, key_level, press_pulse, release_pulse, long_pulse},
                        {28'd0, m_lvl, e_press, e_rel, e_long});
    np += int'(press_pulse);
    nr += int'(release_pulse);
    nl += int'(long_pulse);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    #2;
    sp = np; sr = nr; sl = nl;
  endtask

  task automatic expect_counts(input string tag, input int dp, input int dr, input int dl);
    #2;
    check_eq({tag, "_press"},   np - sp, dp);
    check_eq({tag, "_release"}, nr - sr, dr);
    check_eq({tag, "_long"},    nl - sl, dl);
  endtask

  task automatic measure_press(input string tag);
    lat = 0;
    while (press_pulse !== 1'b1 && lat < 12 * P) begin
      @(negedge clk);
      lat++;
    end
    check_eq(tag, (lat >= 9 * P + 3 && lat <= 10 * P + 2), 1);
  endtask

  task automatic bounce(input int nclk, input int half);
    repeat (nclk / half) begin
      key_n = ~key_n;
      wait_clk(half);
    end
  endtask

  task automatic pulse_reset_check(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_eq(tag, {28'd0, key_level, press_pulse, release_pulse, long_pulse}, 32'd0);
    key_n = 1'b1;
    wait_clk(3);
    #2 reset = 1'b0;
  endtask

  initial begin
    wait_clk(3);
    check_eq("reset_state", {28'd0, key_level, press_pulse, release_pulse, long_pulse}, 32'd0);
    #2 reset = 1'b0;
    wait_clk(3 * P);

    snap();
    key_n = 1'b0;
    measure_press("clean_latency");
    wait_clk(20 * P);
    check_eq("clean_level", key_level, 1);
    key_n = 1'b1;
    wait_clk(30 * P);
    check_eq("clean_released", key_level, 0);
    expect_counts("clean", 1, 1, 0);

    snap();
    bounce(5 * P, 5);
    key_n = 1'b0;
    wait_clk(30 * P);
    bounce(5 * P, 5);
    key_n = 1'b1;
    wait_clk(30 * P);
    expect_counts("bounce", 1, 1, 0);

    snap();
    key_n = 1'b0;
    wait_clk(9 * P);
    key_n = 1'b1;
    wait_clk(20 * P);
    check_eq("glitch_level", key_level, 0);
    expect_counts("glitch", 0, 0, 0);

    snap();
    key_n = 1'b0;
    wait_clk(1000 * P);
    check_eq("long_level", key_level, 1);
    expect_counts("long_held", 1, 0, 1);
    key_n = 1'b1;
    wait_clk(30 * P);
    expect_counts("long_done", 1, 1, 1);

    snap();
    key_n = 1'b0;
    wait_clk(6 * P);
    pulse_reset_check("rst_press_wait");
    wait_clk(20 * P);
    expect_counts("rst_pw", 0, 0, 0);

    key_n = 1'b0;
    wait_clk(15 * P);
    check_eq("rst_rw_pressed", key_level, 1);
    snap();
    key_n = 1'b1;
    wait_clk(4 * P);
    pulse_reset_check("rst_release_wait");
    wait_clk(20 * P);
    expect_counts("rst_rw", 0, 0, 0);

    snap();
    @(negedge clk);
    #2 reset = 1'b1;
    key_n = 1'b0;
    wait_clk(3);
    #2 reset = 1'b0;
    measure_press("held_reset_latency");
    wait_clk(20 * P);
    expect_counts("held_reset", 1, 0, 0);
    key_n = 1'b1;
    wait_clk(30 * P);

    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        bounce(int'($urandom_range(2, 8)) * P, int'($urandom_range(1, 7)));
      end else begin
        key_n = 1'($urandom_range(0, 1));
        wait_clk(int'($urandom_range(1, 14)) * P);
      end
    end
    key_n = 1'b1;
    wait_clk(20 * P);
    check_eq("final_level", key_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
